measure_counter_update: RTL and testbench

//  Write side of the ping-pong measurement RAMs. Takes per-packet (id, length) events and

---
 rtl/measure_counter_update_pkg.sv | 31 +++
 rtl/measure_epoch_timer.sv | 34 +++
 rtl/measure_counter_update.sv | 194 +++++++++++++++++++
 tb/tb_measure_counter_update.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/measure_counter_update_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : measure_counter_update_pkg                                      |
// | Purpose  : Shared definitions for the measurement RAM write side and the   |
// |            cut/report block: FSM states, bank encodings, width defaults.   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package measure_counter_update_pkg;

  localparam int C_ID_WIDTH_DEF      = 12;
  localparam int C_COUNTER_WIDTH_DEF = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WAIT = 2'd2,
    S_WR   = 2'd3
  } state_t;

  typedef enum logic {
    BANK1 = 1'b0,
    BANK2 = 1'b1
  } bank_t;

  function automatic bank_t other_bank(input bank_t b);
    return (b == BANK1) ? BANK2 : BANK1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/measure_epoch_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : measure_epoch_timer                                             |
// | Purpose  : Free-running epoch counter 0..EPOCH_CYCLES-1 with a one-cycle   |
// |            terminal-count flag while the count sits at its last value.     |
// | Ports    : clk, rst (sync, active-high), tc (terminal count, comb.)        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module measure_epoch_timer #(
  parameter int EPOCH_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  output logic tc
);

  localparam int CW = $clog2(EPOCH_CYCLES);

  logic [CW-1:0] r_count;

  assign tc = (r_count == CW'(EPOCH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/measure_counter_update.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : measure_counter_update                                          |
// | Purpose  : Write side of the ping-pong measurement RAMs. Each accepted     |
// |            (id, length) event does a read-modify-write on port A of the    |
// |            active bank, adding length (or 1) with saturation. At each      |
// |            epoch boundary the banks swap and the drained bank is flagged   |
// |            readable for the cut/report block.                              |
// | Ports    : clk, rst            clock, sync active-high reset               |
// |            in_valid/in_id/in_length, out_in_ready   event handshake        |
// |            out_ram_{en,wen,addr,din}{1,2}a, in_ram_dout{1,2}a  RAM port A  |
// |            out_ready_read_{1,2}  bank frozen for readout (level)           |
// |            out_drop_cnt          events dropped for out-of-range id        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module measure_counter_update
  import measure_counter_update_pkg::*;
#(
  parameter int C_LENGTH_WIDTH  = 16,
  parameter int C_ID_WIDTH      = C_ID_WIDTH_DEF,
  parameter int C_COUNTER_WIDTH = C_COUNTER_WIDTH_DEF,
  parameter int ID_NUMBER       = 8,
  parameter int C_MODE          = 1,
  parameter int EPOCH_CYCLES    = 1000000,
  parameter int RAM_LATENCY     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [C_ID_WIDTH-1:0]      in_id,
  input  logic [C_LENGTH_WIDTH-1:0]  in_length,
  output logic                       out_in_ready,
  output logic                       out_ram_en1a,
  output logic                       out_ram_wen1a,
  output logic [C_ID_WIDTH-1:0]      out_ram_addr1a,
  output logic [C_COUNTER_WIDTH-1:0] out_ram_din1a,
  input  logic [C_COUNTER_WIDTH-1:0] in_ram_dout1a,
  output logic                       out_ram_en2a,
  output logic                       out_ram_wen2a,
  output logic [C_ID_WIDTH-1:0]      out_ram_addr2a,
  output logic [C_COUNTER_WIDTH-1:0] out_ram_din2a,
  input  logic [C_COUNTER_WIDTH-1:0] in_ram_dout2a,
  output logic                       out_ready_read_1,
  output logic                       out_ready_read_2,
  output logic [15:0]                out_drop_cnt
);

  // One extra bit over the wider operand so the sum can never wrap before
  // the saturation compare.
  localparam int SUM_W  = ((C_COUNTER_WIDTH > C_LENGTH_WIDTH) ? C_COUNTER_WIDTH : C_LENGTH_WIDTH) + 1;
  localparam int WAIT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  localparam logic [C_COUNTER_WIDTH-1:0] C_COUNT_MAX = '1;
  localparam logic [WAIT_W-1:0]          C_WAIT_LAST = WAIT_W'(RAM_LATENCY - 1);

  state_t                     r_state, w_state_next;
  bank_t                      r_bank, w_bank_next;
  logic                       r_pending, w_pending_next;
  logic [WAIT_W-1:0]          r_wait_cnt, w_wait_cnt_next;
  logic [SUM_W-1:0]           r_inc, w_inc_next;
  logic                       r_en, w_en_next;
  logic                       r_wen, w_wen_next;
  logic [C_ID_WIDTH-1:0]      r_addr, w_addr_next;
  logic [C_COUNTER_WIDTH-1:0] r_din, w_din_next;
  logic [15:0]                r_drop_cnt, w_drop_cnt_next;

  logic                       w_tc;
  logic                       w_id_ok;
  logic [C_COUNTER_WIDTH-1:0] w_dout;
  logic [SUM_W-1:0]           w_sum;
  logic [C_COUNTER_WIDTH-1:0] w_sat;

  measure_epoch_timer #(
    .EPOCH_CYCLES (EPOCH_CYCLES)
  ) u_epoch_timer (
    .clk (clk),
    .rst (rst),
    .tc  (w_tc)
  );

  assign w_id_ok = (int'(in_id) < ID_NUMBER);

  // The bank cannot change while an RMW is in flight, so the active-bank
  // select also picks the read data of the operation in progress.
  assign w_dout = (r_bank == BANK1) ? in_ram_dout1a : in_ram_dout2a;
  assign w_sum  = SUM_W'(w_dout) + r_inc;
  assign w_sat  = (w_sum > SUM_W'(C_COUNT_MAX)) ? C_COUNT_MAX : w_sum[C_COUNTER_WIDTH-1:0];

  always_comb begin
    w_state_next    = r_state;
    w_bank_next     = r_bank;
    // A new epoch boundary always requests a swap, even on the cycle that
    // services the previous request.
    w_pending_next  = r_pending | w_tc;
    w_wait_cnt_next = r_wait_cnt;
    w_inc_next      = r_inc;
    w_en_next       = r_en;
    w_wen_next      = r_wen;
    w_addr_next     = r_addr;
    w_din_next      = r_din;
    w_drop_cnt_next = r_drop_cnt;

    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_bank_next    = other_bank(r_bank);
          w_pending_next = w_tc;
        end else if (in_valid) begin
          if (w_id_ok) begin
            w_state_next = S_RD;
            w_en_next    = 1'b1;
            w_addr_next  = in_id;
            w_inc_next   = (C_MODE == 0) ? SUM_W'(1) : SUM_W'(in_length);
          end else begin
            w_drop_cnt_next = r_drop_cnt + 16'd1;
          end
        end
      end
      S_RD: begin
        w_state_next    = S_WAIT;
        w_wait_cnt_next = '0;
      end
      S_WAIT: begin
        if (r_wait_cnt == C_WAIT_LAST) begin
          // Read data is valid on the last wait cycle; the saturated sum
          // is registered straight into the write data.
          w_state_next = S_WR;
          w_wen_next   = 1'b1;
          w_din_next   = w_sat;
        end else begin
          w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
        end
      end
      S_WR: begin
        w_state_next = S_IDLE;
        w_en_next    = 1'b0;
        w_wen_next   = 1'b0;
        w_addr_next  = '0;
        w_din_next   = '0;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bank     <= BANK1;
      r_pending  <= 1'b0;
      r_wait_cnt <= '0;
      r_inc      <= '0;
      r_en       <= 1'b0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_bank     <= w_bank_next;
      r_pending  <= w_pending_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_inc      <= w_inc_next;
      r_en       <= w_en_next;
      r_wen      <= w_wen_next;
      r_addr     <= w_addr_next;
      r_din      <= w_din_next;
      r_drop_cnt <= w_drop_cnt_next;
    end
  end

  assign out_in_ready = (r_state == S_IDLE) && !r_pending;

  // Only the active bank sees port A activity; the other bank's port A is
  // held at zero while the cut block owns it.
  assign out_ram_en1a   = (r_bank == BANK1) && r_en;
  assign out_ram_wen1a  = (r_bank == BANK1) && r_wen;
  assign out_ram_addr1a = (r_bank == BANK1) ? r_addr : '0;
  assign out_ram_din1a  = (r_bank == BANK1) ? r_din  : '0;
  assign out_ram_en2a   = (r_bank == BANK2) && r_en;
  assign out_ram_wen2a  = (r_bank == BANK2) && r_wen;
  assign out_ram_addr2a = (r_bank == BANK2) ? r_addr : '0;
  assign out_ram_din2a  = (r_bank == BANK2) ? r_din  : '0;

  // The frozen bank is always the inactive one, so the two flags are
  // complementary by construction.
  assign out_ready_read_1 = (r_bank == BANK2);
  assign out_ready_read_2 = (r_bank == BANK1);

  assign out_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_measure_counter_update.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_measure_counter_update                                       |
// | Purpose  : Self-checking bench for measure_counter_update with an 8-entry  |
// |            latency-2 dual-bank RAM model and a behavioural reference.      |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_measure_counter_update;

  localparam int EPOCH = 64;
  localparam int IDN   = 8;
  localparam int CMAX  = 1048575;
  localparam int RMW   = 4;   // busy cycles after the accept cycle

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_id;
  logic [15:0] in_length;
  logic        ready;
  logic        en1, wen1, en2, wen2;
  logic [11:0] addr1, addr2;
  logic [19:0] din1, din2, dout1, dout2;
  logic        rr1, rr2;
  logic [15:0] drop;

  always #5 clk = ~clk;

  measure_counter_update #(
    .C_LENGTH_WIDTH (16), .C_ID_WIDTH (12), .C_COUNTER_WIDTH (20),
    .ID_NUMBER (IDN), .C_MODE (1), .EPOCH_CYCLES (EPOCH), .RAM_LATENCY (2)
  ) u_dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_id (in_id), .in_length (in_length),
    .out_in_ready (ready),
    .out_ram_en1a (en1), .out_ram_wen1a (wen1), .out_ram_addr1a (addr1),
    .out_ram_din1a (din1), .in_ram_dout1a (dout1),
    .out_ram_en2a (en2), .out_ram_wen2a (wen2), .out_ram_addr2a (addr2),
    .out_ram_din2a (din2), .in_ram_dout2a (dout2),
    .out_ready_read_1 (rr1), .out_ready_read_2 (rr2),
    .out_drop_cnt (drop)
  );

  // RAM model: two banks, port A read-first with two cycles of latency.
  // Bank clear stands in for the cut block draining a bank; preload seeds values.
  logic [19:0] mem [2][8];
  logic [19:0] pipe1, pipe2;
  logic [1:0]  clr_mask;
  logic        ld_req;
  logic        ld_bank;
  logic [2:0]  ld_addr;
  logic [19:0] ld_val;

  always @(posedge clk) begin
    if (en1) begin
      if (wen1) mem[0][addr1[2:0]] <= din1;
      pipe1 <= mem[0][addr1[2:0]];
    end
    if (en2) begin
      if (wen2) mem[1][addr2[2:0]] <= din2;
      pipe2 <= mem[1][addr2[2:0]];
    end
    dout1 <= pipe1;
    dout2 <= pipe2;
    if (ld_req) mem[ld_bank][ld_addr] <= ld_val;
    for (int b = 0; b < 2; b++)
      if (clr_mask[b])
        for (int i = 0; i < 8; i++) mem[b][i] <= '0;
  end

  typedef struct {
    int cyc;
    bit rdy, rr1, rr2, en1, en2, wen1, wen2, zero;
    int drop;
  } stat_t;

  typedef struct {
    int bank;
    int addr;
    int val;
    int due;
    int old;
  } wr_t;

  stat_t sq[$];
  wr_t   wq[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model state
  int m_timer, m_busy, m_bank, m_drop, cyc;
  bit m_pending, m_zero;
  int m_cnt [2][8];

  // Monitor: compares everything the DUT shows each cycle against what the
  // driver predicted for that cycle, and pops an expected write on each wen.
  always @(negedge clk) begin : mon
    stat_t s;
    wr_t   w;
    logic [22:0] exp_v, act_v;
    int abank;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      exp_v = {s.rdy, s.rr1, s.rr2, s.en1, s.en2, s.wen1, s.wen2, 16'(s.drop)};
      act_v = {ready, rr1, rr2, en1, en2, wen1, wen2, drop};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL status cyc=%0d {rdy,rr1,rr2,en1,en2,wen1,wen2,drop} actual=%b required=%b",
                 s.cyc, act_v, exp_v);
      end
      if (s.zero) begin
        n_checks++;
        if ({addr1, addr2, din1, din2} !== '0) begin
          n_errors++;
          $display("FAIL reset_ports cyc=%0d actual addr1=%0h addr2=%0h din1=%0h din2=%0h required all 0",
                   s.cyc, addr1, addr2, din1, din2);
        end
      end
      if (wen1 || wen2) begin
        n_checks++;
        abank = wen1 ? 0 : 1;
        if (wq.size() == 0) begin
          n_errors++;
          $display("FAIL write cyc=%0d actual unexpected write bank=%0d required none", s.cyc, abank + 1);
        end else begin
          w = wq.pop_front();
          if (abank != w.bank || (wen1 && wen2) ||
              int'(abank == 0 ? addr1 : addr2) != w.addr ||
              int'(abank == 0 ? din1 : din2) != w.val || s.cyc != w.due) begin
            n_errors++;
            $display("FAIL write actual bank=%0d addr=%0d din=%0h cyc=%0d required bank=%0d addr=%0d din=%0h cyc=%0d",
                     abank + 1, abank == 0 ? addr1 : addr2, abank == 0 ? din1 : din2, s.cyc,
                     w.bank + 1, w.addr, w.val, w.due);
          end
        end
      end
    end
  end

  // Advance the reference by one clock, given the inputs presented this cycle.
  task automatic model_step(input bit r, input bit v, input int id, input int len);
    bit  tc;
    wr_t w;
    int  sum;
    tc = (m_timer == EPOCH - 1);
    if (r) begin
      // An RMW whose write has not yet appeared is abandoned: counter unchanged.
      while (wq.size() > 0 && wq[wq.size()-1].due > cyc) begin
        w = wq.pop_back();
        m_cnt[w.bank][w.addr] = w.old;
      end
      m_timer = 0; m_busy = 0; m_pending = 0; m_bank = 0; m_drop = 0; m_zero = 1;
      return;
    end
    m_zero = 0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (m_pending) begin
      m_bank    = 1 - m_bank;
      m_pending = 0;
      clr_mask[m_bank] = 1'b1;
      for (int i = 0; i < 8; i++) m_cnt[m_bank][i] = 0;
    end else if (v) begin
      if (id < IDN) begin
        sum    = m_cnt[m_bank][id] + len;
        w.bank = m_bank;
        w.addr = id;
        w.old  = m_cnt[m_bank][id];
        w.val  = (sum > CMAX) ? CMAX : sum;
        w.due  = cyc + RMW;
        m_cnt[m_bank][id] = w.val;
        wq.push_back(w);
        m_busy = RMW;
      end else begin
        m_drop = (m_drop + 1) % 65536;
      end
    end
    if (tc) m_pending = 1;
    m_timer = (m_timer + 1) % EPOCH;
  endtask

  task automatic tick(input bit r, input bit v, input int id, input int len);
    stat_t s;
    s.cyc  = cyc;
    s.rdy  = (m_busy == 0) && !m_pending;
    s.rr1  = (m_bank == 1);
    s.rr2  = (m_bank == 0);
    s.en1  = (m_busy > 0) && (m_bank == 0);
    s.en2  = (m_busy > 0) && (m_bank == 1);
    s.wen1 = (m_busy == 1) && (m_bank == 0);
    s.wen2 = (m_busy == 1) && (m_bank == 1);
    s.zero = m_zero;
    s.drop = m_drop;
    sq.push_back(s);
    rst       = r;
    in_valid  = v;
    in_id     = 12'(id);
    in_length = 16'(len);
    model_step(r, v, id, len);
    @(posedge clk);
    #1;
    clr_mask = 2'b00;
    ld_req   = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0);
  endtask

  // Hold the event until the reference says it was accepted.
  task automatic send(input int id, input int len);
    bit acc;
    int guard;
    guard = 0;
    do begin
      acc = (m_busy == 0) && !m_pending;
      tick(0, 1, id, len);
      guard++;
    end while (!acc && guard < 100);
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout id=%0d actual not accepted required accepted within 100 cycles", id);
    end
  endtask

  task automatic preload(input int bank, input int addr, input int val);
    ld_req  = 1'b1;
    ld_bank = bank[0];
    ld_addr = addr[2:0];
    ld_val  = 20'(val);
    m_cnt[bank][addr] = val;
    tick(0, 0, 0, 0);
  endtask

  initial begin
    int id, len;
    rst = 1'b1; in_valid = 1'b0; in_id = '0; in_length = '0;
    clr_mask = 2'b11; ld_req = 1'b0; ld_bank = 1'b0; ld_addr = '0; ld_val = '0;
    m_timer = 0; m_busy = 0; m_bank = 0; m_drop = 0; m_pending = 0; m_zero = 1; cyc = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++) m_cnt[b][i] = 0;
    @(posedge clk);
    #1;
    clr_mask = 2'b00;
    repeat (3) tick(1, 0, 0, 0);

    // Single event, then back-to-back events on one id
    send(3, 100);  idle(6);
    send(5, 40);   send(5, 60);  idle(6);

    // Saturation
    preload(0, 2, 20'hFFFF0);
    send(2, 100);  idle(6);

    // Out-of-range ids are dropped without RAM access
    send(9, 123);  send(4095, 1);  idle(2);

    // Epoch boundary inside an accepted RMW
    for (int k = 0; k < EPOCH && m_timer != EPOCH - 3; k++) tick(0, 0, 0, 0);
    send(1, 7);    send(1, 5);   idle(6);

    // Reset during the wait phase abandons the write; the old value survives
    send(6, 50);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    idle(3);
    send(6, 1);    idle(6);

    // Randomized traffic with occasional resets and out-of-range ids
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 3)) tick(0, 0, 0, 0);
      if ($urandom_range(0, 79) == 0) tick(1, 0, 0, 0);
      id  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 4095)) : int'($urandom_range(0, 7));
      len = int'($urandom_range(0, 65535));
      send(id, len);
    end
    idle(10);

    n_checks++;
    if (wq.size() != 0) begin
      n_errors++;
      $display("FAIL drain actual %0d writes outstanding required 0", wq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
